// File: rtl/adv7393_timing_gen.sv
// Raster timing generator for an ADV7393 pixel port: free-running H/V counters
// with registered DE, syncs and start strobes, under a start/stop/drain control FSM.
module adv7393_timing_gen #(
  parameter int unsigned H_ACTIVE = 720,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 62,
  parameter int unsigned H_TOTAL  = 858,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 9,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_TOTAL  = 525
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  output logic        busy,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic        de,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        frame_start,
  output logic        line_start
);

  localparam int unsigned XW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned YW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int unsigned XC = XW + 1;
  localparam int unsigned YC = YW + 1;

  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
  // One extra bit so a window edge equal to the total still fits.
  localparam logic [XC-1:0] X_DE_END = XC'(H_ACTIVE);
  localparam logic [XC-1:0] X_HS_BEG = XC'(H_ACTIVE + H_FP);
  localparam logic [XC-1:0] X_HS_END = XC'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YC-1:0] Y_DE_END = YC'(V_ACTIVE);
  localparam logic [YC-1:0] Y_VS_BEG = YC'(V_ACTIVE + V_FP);
  localparam logic [YC-1:0] Y_VS_END = YC'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [XW-1:0] w_x_nxt;
  logic [YW-1:0] w_y_nxt;
  logic          w_last_x;
  logic          w_last_pix;

  logic          r_de;
  logic          r_hsync_n;
  logic          r_vsync_n;
  logic          r_frame_start;
  logic          r_line_start;
  logic          w_busy_nxt;
  logic          w_de_nxt;
  logic          w_hsync_n_nxt;
  logic          w_vsync_n_nxt;
  logic          w_frame_start_nxt;
  logic          w_line_start_nxt;

  assign w_last_x   = (r_x == X_LAST);
  assign w_last_pix = w_last_x && (r_y == Y_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start always wins over a simultaneous stop.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (stop && !start) w_state_nxt = w_last_pix ? S_IDLE : S_DRAIN;
      end
      S_DRAIN: begin
        if (start)           w_state_nxt = S_RUN;
        else if (w_last_pix) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next counter position; held at the origin whenever the next state is idle.
  always_comb begin
    w_x_nxt = '0;
    w_y_nxt = '0;
    if (r_state != S_IDLE && w_state_nxt != S_IDLE) begin
      if (!w_last_x) begin
        w_x_nxt = r_x + 1'b1;
        w_y_nxt = r_y;
      end else begin
        w_x_nxt = '0;
        w_y_nxt = (r_y == Y_LAST) ? '0 : r_y + 1'b1;
      end
    end
  end

  // Output decode against the next position, so the registered flags line up
  // with the counter value they describe.
  always_comb begin
    w_busy_nxt        = (w_state_nxt != S_IDLE);
    w_de_nxt          = w_busy_nxt
                        && ({1'b0, w_x_nxt} < X_DE_END)
                        && ({1'b0, w_y_nxt} < Y_DE_END);
    w_hsync_n_nxt     = !(w_busy_nxt
                        && ({1'b0, w_x_nxt} >= X_HS_BEG)
                        && ({1'b0, w_x_nxt} <  X_HS_END));
    w_vsync_n_nxt     = !(w_busy_nxt
                        && ({1'b0, w_y_nxt} >= Y_VS_BEG)
                        && ({1'b0, w_y_nxt} <  Y_VS_END));
    w_line_start_nxt  = w_busy_nxt && (w_x_nxt == '0);
    w_frame_start_nxt = w_line_start_nxt && (w_y_nxt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x           <= '0;
      r_y           <= '0;
      r_de          <= 1'b0;
      r_hsync_n     <= 1'b1;
      r_vsync_n     <= 1'b1;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
    end else begin
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_de          <= w_de_nxt;
      r_hsync_n     <= w_hsync_n_nxt;
      r_vsync_n     <= w_vsync_n_nxt;
      r_frame_start <= w_frame_start_nxt;
      r_line_start  <= w_line_start_nxt;
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign pix_x       = 11'(r_x);
  assign pix_y       = 10'(r_y);
  assign de          = r_de;
  assign hsync_n     = r_hsync_n;
  assign vsync_n     = r_vsync_n;
  assign frame_start = r_frame_start;
  assign line_start  = r_line_start;

endmodule

// File: tb/tb_adv7393_timing_gen.sv
// Directed bench for adv7393_timing_gen on a small raster, with a frame-position
// reference model compared every cycle plus hand-computed spot checks.
module tb_adv7393_timing_gen;

  localparam int HA = 4, HFP = 1, HS = 2, HT = 10;
  localparam int VA = 3, VFP = 1, VS = 1, VT = 6;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        busy, de, hsync_n, vsync_n, frame_start, line_start;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: running flag, pending-halt flag, linear pixel index in frame.
  bit m_active = 1'b0;
  bit m_halt   = 1'b0;
  int m_p      = 0;

  always #5 clk = ~clk;

  adv7393_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .busy(busy), .pix_x(pix_x), .pix_y(pix_y), .de(de),
    .hsync_n(hsync_n), .vsync_n(vsync_n),
    .frame_start(frame_start), .line_start(line_start)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_halt   = 1'b0;
      m_p      = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_halt   = 1'b0;
        m_p      = 0;
      end
    end else begin
      if (start)     m_halt = 1'b0;
      else if (stop) m_halt = 1'b1;
      if (m_p == FRAME - 1 && m_halt) begin
        m_active = 1'b0;
        m_halt   = 1'b0;
        m_p      = 0;
      end else begin
        m_p = (m_p == FRAME - 1) ? 0 : m_p + 1;
      end
    end
  end

  always @(negedge clk) begin : cmp
    int ex, ey;
    if (rst_n) begin
      ex = m_active ? m_p % HT : 0;
      ey = m_active ? m_p / HT : 0;
      chk("busy", busy, m_active);
      chk("pix_x", pix_x, ex);
      chk("pix_y", pix_y, ey);
      chk("de", de, m_active && ex < HA && ey < VA);
      chk("hsync_n", hsync_n, !(m_active && ex >= HA + HFP && ex < HA + HFP + HS));
      chk("vsync_n", vsync_n, !(m_active && ey >= VA + VFP && ey < VA + VFP + VS));
      chk("frame_start", frame_start, m_active && m_p == 0);
      chk("line_start", line_start, m_active && ex == 0);
    end
  end

  // Called at a negedge: hold the strobes for exactly one sampling edge.
  task automatic pulse(input bit s_start, input bit s_stop);
    start = s_start;
    stop  = s_stop;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_pix(input int x, input int y, input int lim);
    bit found = 1'b0;
    for (int i = 0; i < lim && !found; i++) begin
      @(negedge clk);
      if (busy && pix_x == 11'(x) && pix_y == 10'(y)) found = 1'b1;
    end
    chk($sformatf("reach_%0d_%0d", x, y), found, 1);
  endtask

  initial begin
    int de_cnt, vs_cnt, fs_extra;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_hsync_n", hsync_n, 1);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Idle after reset with no start
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_de", de, 0);
      chk("idle_hsync_n", hsync_n, 1);
      chk("idle_vsync_n", vsync_n, 1);
    end
    pulse(1'b0, 1'b1);
    chk("stop_in_idle_busy", busy, 0);

    // Start latency and the first two frames
    pulse(1'b1, 1'b0);
    chk("start_busy", busy, 1);
    chk("start_x", pix_x, 0);
    chk("start_y", pix_y, 0);
    chk("start_de", de, 1);
    chk("start_fs", frame_start, 1);
    chk("start_ls", line_start, 1);
    fs_extra = 0;
    for (int f = 0; f < 2; f++) begin
      de_cnt = 0;
      vs_cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
        if (f == 0 && i == 4) chk("de_off_x4", de, 0);
        if (f == 0 && (i == 5 || i == 6)) chk("hsync_low", hsync_n, 0);
        if (f == 0 && i == 7) chk("hsync_high_x7", hsync_n, 1);
        if (i != 0 && frame_start) fs_extra++;
        if (de) de_cnt++;
        if (!vsync_n) vs_cnt++;
        start = (f == 0 && i == 30) || (f == 1 && i == 20);
        stop  = (f == 1 && i == 20);
        @(negedge clk);
      end
      start = 1'b0;
      stop  = 1'b0;
      chk("de_per_frame", de_cnt, 12);
      chk("vsync_per_frame", vs_cnt, 10);
      chk("frame_period_fs", frame_start, 1);
      chk("frame_period_x", pix_x, 0);
      chk("frame_period_y", pix_y, 0);
    end
    chk("extra_frame_start", fs_extra, 0);

    // Stop at (3,1): frame completes, then idle
    wait_pix(3, 1, 100);
    pulse(1'b0, 1'b1);
    wait_pix(9, 5, 100);
    @(negedge clk);
    chk("drain_end_busy", busy, 0);
    chk("drain_end_x", pix_x, 0);
    chk("drain_end_y", pix_y, 0);
    fs_extra = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (frame_start) fs_extra++;
    end
    chk("no_second_frame", fs_extra, 0);

    // Start+stop in IDLE goes to RUN; stop on the last pixel halts immediately
    pulse(1'b1, 1'b1);
    chk("both_idle_busy", busy, 1);
    chk("both_idle_fs", frame_start, 1);
    wait_pix(9, 5, 100);
    pulse(1'b0, 1'b1);
    chk("stop_last_busy", busy, 0);
    chk("stop_last_x", pix_x, 0);

    // Stop then start in the same frame: no halt
    pulse(1'b1, 1'b0);
    wait_pix(2, 1, 100);
    pulse(1'b0, 1'b1);
    chk("drain_busy", busy, 1);
    wait_pix(5, 2, 100);
    pulse(1'b1, 1'b0);
    wait_pix(9, 5, 100);
    @(negedge clk);
    chk("resume_busy", busy, 1);
    chk("resume_fs", frame_start, 1);

    // Asynchronous reset mid-frame
    wait_pix(2, 2, 100);
    chk("pre_rst_de", de, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_x", pix_x, 0);
    chk("arst_y", pix_y, 0);
    chk("arst_de", de, 0);
    chk("arst_hsync_n", hsync_n, 1);
    chk("arst_vsync_n", vsync_n, 1);
    chk("arst_fs", frame_start, 0);
    chk("arst_ls", line_start, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    pulse(1'b1, 1'b0);
    chk("restart_x", pix_x, 0);
    chk("restart_y", pix_y, 0);
    chk("restart_fs", frame_start, 1);
    repeat (15) @(negedge clk);
    chk("restart_x15", pix_x, 5);
    chk("restart_y15", pix_y, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adv7393_timing_gen.md
ADV7393_TIMING_GEN -- requirements
Module: adv7393_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 720: active pixels per line.
REQ-002 SHALL have parameter H_FP, default 16: horizontal front porch, in clocks.
REQ-003 SHALL have parameter H_SYNC, default 62: hsync width, in clocks.
REQ-004 SHALL have parameter H_TOTAL, default 858: clocks per line.
REQ-005 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-006 SHALL have parameter V_FP, default 9: vertical front porch, in lines.
REQ-007 SHALL have parameter V_SYNC, default 6: vsync width, in lines.
REQ-008 SHALL have parameter V_TOTAL, default 525: lines per frame.
REQ-009 SHALL have port clk, input, 1 bit: single clock; every flop is on its rising edge.
REQ-010 SHALL have port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-011 SHALL have port start, input, 1 bit: single-cycle strobe that begins frame generation.
REQ-012 SHALL have port stop, input, 1 bit: single-cycle strobe that requests a halt at the end of the current frame.
REQ-013 SHALL have port busy, output, 1 bit: high while not IDLE.
REQ-014 SHALL have port pix_x, output, 11 bits: horizontal counter.
REQ-015 SHALL have port pix_y, output, 10 bits: vertical counter.
REQ-016 SHALL have port de, output, 1 bit: active-video enable.
REQ-017 SHALL have port hsync_n, output, 1 bit: horizontal sync, active-low.
REQ-018 SHALL have port vsync_n, output, 1 bit: vertical sync, active-low.
REQ-019 SHALL have port frame_start, output, 1 bit: one-cycle pulse on pixel (0,0).
REQ-020 SHALL have port line_start, output, 1 bit: one-cycle pulse at pix_x==0.

Function
REQ-021 SHALL implement FSM states IDLE, RUN and DRAIN.
- IDLE -> RUN on start.
- RUN -> DRAIN on stop.
- DRAIN -> IDLE after the last pixel of the frame.
- DRAIN -> RUN if start arrives before that last pixel.
REQ-022 SHALL make the cycle after start is sampled in IDLE show pix_x=0, pix_y=0, de=1, frame_start=1, line_start=1, busy=1 (latency 1 clock).
REQ-023 SHALL, in RUN/DRAIN, increment pix_x each clock; at H_TOTAL-1 it wraps to 0 and pix_y increments; at pix_y V_TOTAL-1 with pix_x H_TOTAL-1, both wrap to 0.
REQ-024 SHALL, in RUN, restart at (0,0) after wrap with frame_start=1; generation is continuous with no gap cycle.
REQ-025 SHALL, in DRAIN, finish the current frame; the cycle after pixel (H_TOTAL-1, V_TOTAL-1) is IDLE with pix_x=0, pix_y=0, busy=0.
REQ-026 SHALL drive de=1 iff busy and pix_x<H_ACTIVE and pix_y<V_ACTIVE.
REQ-027 SHALL drive hsync_n=0 iff busy and H_ACTIVE+H_FP <= pix_x < H_ACTIVE+H_FP+H_SYNC.
REQ-028 SHALL drive vsync_n=0 iff busy and V_ACTIVE+V_FP <= pix_y < V_ACTIVE+V_FP+V_SYNC, for the whole of each such line.
REQ-029 SHALL drive de, hsync_n, vsync_n, frame_start and line_start from registers, cycle-aligned with the pix_x/pix_y value they describe.
REQ-030 SHALL ignore start in RUN, with no counter restart.
REQ-031 SHALL ignore stop in IDLE.
REQ-032 SHALL give start priority when start and stop are both high in IDLE: go to RUN.
REQ-033 SHALL stay in RUN when start and stop are both high in RUN: stop is ignored.
REQ-034 SHALL treat stop arriving on the last pixel of a frame as applying to that frame: the next cycle is IDLE.
REQ-035 SHALL hold in IDLE: pix_x=0, pix_y=0, de=0, hsync_n=1, vsync_n=1, strobes 0.
REQ-036 SHALL size counters to the parameters with no overflow past H_TOTAL-1 or V_TOTAL-1; behaviour is undefined if H_ACTIVE+H_FP+H_SYNC>H_TOTAL (or the vertical equivalent).

Reset
REQ-037 SHALL, while rst_n=0, asynchronously force IDLE, busy=0, pix_x=0, pix_y=0, de=0, hsync_n=1, vsync_n=1, frame_start=0, line_start=0.
REQ-038 SHALL treat rst_n asserted mid-frame as abandoning the frame, with outputs at reset values immediately.
REQ-039 SHALL, after rst_n deasserts, stay in IDLE until a start strobe.

Verification
Small parameter set for scenarios 2-6: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_TOTAL=10, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_TOTAL=6.
REQ-040 SHALL cover: rst_n low then high, no start -> 20 clocks of busy=0, de=0, hsync_n=1, vsync_n=1.
REQ-041 SHALL cover: start pulse at cycle N -> cycle N+1: (0,0), de=1, frame_start=1; then hsync_n=0 at pix_x 5..6; de=0 at pix_x 4..9.
REQ-042 SHALL cover: run 2 frames -> frame_start every 60 clocks; vsync_n=0 for all 10 clocks of pix_y=4; de high for 12 clocks per frame.
REQ-043 SHALL cover: stop at pixel (3,1) -> frame completes; busy=0 the cycle after (9,5); no second frame_start.
REQ-044 SHALL cover: stop at (9,5); stop then start within the same frame -> IDLE next cycle and no halt, respectively.
REQ-045 SHALL cover: rst_n low at (2,2) -> outputs reset within the same cycle; restart via start begins at (0,0).
